// File: rtl/scp_079_staged_pkg.sv
// Shared definitions for the staged SCP-079 intrusion FSM.
// Holds the externally visible state codes used by the FSM, its interface and the bench.
package scp_079_staged_pkg;

   localparam logic [2:0] ST_LAY_LOW = 3'd0;
   localparam logic [2:0] ST_CHEAT   = 3'd1;
   localparam logic [2:0] ST_ATTACK  = 3'd2;
   localparam logic [2:0] ST_FAIL    = 3'd4;
   localparam logic [2:0] ST_CONNECT = 3'd5;

   // Width needed to hold the values 0..n
   function automatic int unsigned count_w(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/scp_079_staged_if.sv
// Alert/status bundle between the alert-light decoder (master) and the FSM (slave).
// Inputs: green, yellow, red, restart.
// Status: state, level, timer, stage_mask, cheat_out, connected, failed, cheat_cnt.
interface scp_079_staged_if #(
   parameter int unsigned STAGES     = 3,
   parameter int unsigned TW         = 6,
   parameter int unsigned MAX_CHEATS = 0
);
   import scp_079_staged_pkg::*;

   localparam int unsigned LW = count_w(STAGES);
   localparam int unsigned CW = count_w(MAX_CHEATS + 1);

   logic              green;
   logic              yellow;
   logic              red;
   logic              restart;
   logic [2:0]        state;
   logic [LW-1:0]     level;
   logic [TW-1:0]     timer;
   logic [STAGES-1:0] stage_mask;
   logic              cheat_out;
   logic              connected;
   logic              failed;
   logic [CW-1:0]     cheat_cnt;

   modport master (
      output green, yellow, red, restart,
      input  state, level, timer, stage_mask, cheat_out, connected, failed, cheat_cnt
   );

   modport slave (
      input  green, yellow, red, restart,
      output state, level, timer, stage_mask, cheat_out, connected, failed, cheat_cnt
   );

endinterface

// File: rtl/scp_079_staged_dwell_timer.sv
// Saturating dwell counter: counts cycles in the current state/level, never wraps.
// Ports: clock, reset_n (async, active-low), clear (sync), count.
module scp_079_staged_dwell_timer #(
   parameter int unsigned TW = 6
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          clear,
   output logic [TW-1:0] count
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)          count <= '0;
      else if (clear)        count <= '0;
      else if (count != '1)  count <= count + TW'(1);
   end

endmodule

// File: rtl/scp_079_staged.sv
// Staged SCP-079 intrusion FSM: walks an N-stage attack ladder from green/yellow/red alerts,
// with per-level dwell thresholds, a cheat (evade) window, bounded retries and restart.
// Ports: clock, reset_n (async, active-low), bus (slave side of scp_079_staged_if).
module scp_079_staged
   import scp_079_staged_pkg::*;
#(
   parameter int unsigned             STAGES     = 3,
   parameter int unsigned             TW         = 6,
   parameter logic [STAGES*TW-1:0]    STAGE_T    = {6'd9, 6'd20, 6'd35},
   parameter int unsigned             CHEAT_T    = 25,
   parameter int unsigned             MAX_CHEATS = 0,
   parameter bit                      CHEAT_KEEP = 1'b0
) (
   input  logic           clock,
   input  logic           reset_n,
   scp_079_staged_if.slave bus
);

   localparam int unsigned LW = count_w(STAGES);
   localparam int unsigned CW = count_w(MAX_CHEATS + 1);

   logic [2:0]        state_q, state_d;
   logic [LW-1:0]     level_q, level_d, saved_q, saved_d, back_lvl;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW:0]       cnt_inc;
   logic [STAGES-1:0] mask_q, mask_d;
   logic              cheat_q, conn_q, fail_q;
   logic [TW-1:0]     timer;
   logic [TW-1:0]     thr;
   logic              cheat_done;
   logic              go_red, go_yel, go_grn;

   // Priority-resolved alert conditions
   assign go_red = bus.red;
   assign go_yel = bus.yellow & ~bus.red;
   assign go_grn = bus.green & ~bus.yellow & ~bus.red;

   // Dwell threshold of the current level
   always_comb begin
      thr = '0;
      for (int k = 0; k < int'(STAGES); k++)
         if (level_q == LW'(k)) thr = STAGE_T[k*TW +: TW];
   end

   // Saturation covers windows that do not fit in the timer
   assign cheat_done = (timer == '1) || (32'(timer) >= CHEAT_T);
   assign cnt_inc    = {1'b0, cnt_q} + (CW+1)'(1);
   assign back_lvl   = CHEAT_KEEP ? saved_q : '0;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_LAY_LOW;
      else          state_q <= state_d;
   end

   // Next state, level, saved level and cheat count
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      saved_d = saved_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_LAY_LOW, ST_ATTACK: begin
            if (go_red) begin
               saved_d = level_q;
               cnt_d   = cnt_inc[CW] ? cnt_q : cnt_inc[CW-1:0];
               if (MAX_CHEATS != 0 && 32'(cnt_inc) > MAX_CHEATS) state_d = ST_FAIL;
               else                                              state_d = ST_CHEAT;
            end else if (go_yel && level_q != '0) begin
               level_d = level_q - LW'(1);
               state_d = (level_d == '0) ? ST_LAY_LOW : ST_ATTACK;
            end else if (go_grn && timer >= thr) begin
               level_d = level_q + LW'(1);
               state_d = (32'(level_q) + 1 == STAGES) ? ST_CONNECT : ST_ATTACK;
            end
         end
         ST_CHEAT: begin
            if (cheat_done) begin
               if (go_red) begin
                  state_d = ST_FAIL;
               end else begin
                  level_d = back_lvl;
                  state_d = (back_lvl == '0) ? ST_LAY_LOW : ST_ATTACK;
               end
            end
         end
         ST_FAIL, ST_CONNECT: begin
            if (bus.restart) begin
               state_d = ST_LAY_LOW;
               level_d = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_LAY_LOW;
            level_d = '0;
         end
      endcase
   end

   // Thermometer code of the next level
   always_comb begin
      mask_d = '0;
      for (int i = 0; i < int'(STAGES); i++)
         mask_d[i] = (32'(level_d) > i);
   end

   // Registered status outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= '0;
         saved_q <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         cheat_q <= 1'b0;
         conn_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         saved_q <= saved_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         cheat_q <= (state_d == ST_CHEAT);
         conn_q  <= (state_d == ST_CONNECT);
         fail_q  <= (state_d == ST_FAIL);
      end
   end

   // Timer restarts on any state or level change
   scp_079_staged_dwell_timer #(.TW(TW)) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   ((state_d != state_q) || (level_d != level_q)),
      .count   (timer)
   );

   assign bus.state      = state_q;
   assign bus.level      = level_q;
   assign bus.timer      = timer;
   assign bus.stage_mask = mask_q;
   assign bus.cheat_out  = cheat_q;
   assign bus.connected  = conn_q;
   assign bus.failed     = fail_q;
   assign bus.cheat_cnt  = cnt_q;

endmodule

// File: tb/tb_scp_079_staged.sv
// Bench for scp_079_staged: three instances (default, CHEAT_KEEP=1, MAX_CHEATS=2) share stimulus.
module tb_scp_079_staged;
   import scp_079_staged_pkg::*;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] lv;
      logic [5:0] tm;
      logic [2:0] mk;
      logic       ch;
      logic       cn;
      logic       fl;
      logic [1:0] cc;
   } obs_t;

   logic clock, reset_n;
   logic green, yellow, red, restart;
   int   n_chk, n_fail;
   obs_t exp_q[$];
   obs_t got, want;

   scp_079_staged_if #(.STAGES(3), .TW(6), .MAX_CHEATS(0)) bus0 ();
   scp_079_staged_if #(.STAGES(3), .TW(6), .MAX_CHEATS(0)) bus1 ();
   scp_079_staged_if #(.STAGES(3), .TW(6), .MAX_CHEATS(2)) bus2 ();

   assign bus0.green = green;  assign bus0.yellow = yellow;
   assign bus0.red = red;      assign bus0.restart = restart;
   assign bus1.green = green;  assign bus1.yellow = yellow;
   assign bus1.red = red;      assign bus1.restart = restart;
   assign bus2.green = green;  assign bus2.yellow = yellow;
   assign bus2.red = red;      assign bus2.restart = restart;

   scp_079_staged dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
   scp_079_staged #(.CHEAT_KEEP(1'b1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
   scp_079_staged #(.MAX_CHEATS(2)) dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   // Expected observation straight from the status definitions
   function automatic obs_t exp_v(input logic [2:0] st, input int lv, input int tm, input int cc);
      obs_t r;
      r.st = st;
      r.lv = 2'(lv);
      r.tm = 6'(tm);
      r.mk = 3'((1 << lv) - 1);
      r.ch = (st == ST_CHEAT);
      r.cn = (st == ST_CONNECT);
      r.fl = (st == ST_FAIL);
      r.cc = 2'(cc);
      return r;
   endfunction

   function automatic obs_t obs(input int d);
      obs_t r;
      case (d)
         0: r = {bus0.state, bus0.level, bus0.timer, bus0.stage_mask, bus0.cheat_out,
                 bus0.connected, bus0.failed, 2'(bus0.cheat_cnt)};
         1: r = {bus1.state, bus1.level, bus1.timer, bus1.stage_mask, bus1.cheat_out,
                 bus1.connected, bus1.failed, 2'(bus1.cheat_cnt)};
         default: r = {bus2.state, bus2.level, bus2.timer, bus2.stage_mask, bus2.cheat_out,
                 bus2.connected, bus2.failed, 2'(bus2.cheat_cnt)};
      endcase
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      green = 0; yellow = 0; red = 0; restart = 0;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) exp_q.push_back(exp_v(ST_LAY_LOW, 0, 0, 0));
      #1;
      for (int d = 0; d < 3; d++) begin
         got = obs(d); want = exp_q.pop_front(); n_chk++;
         if (got !== want) begin n_fail++; $display("FAIL reset dut%0d: got %h want %h", d, got, want); end
      end
      reset_n = 1'b1;
   endtask

   task automatic test_green_ladder();
      do_reset();
      green = 1;
      exp_q.push_back(exp_v(ST_LAY_LOW, 0, 35, 0)); tick(35);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL green_l0_dwell: got %h want %h", got, want); end
      exp_q.push_back(exp_v(ST_ATTACK, 1, 0, 0)); tick(1);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL green_l1: got %h want %h", got, want); end
      exp_q.push_back(exp_v(ST_ATTACK, 1, 20, 0)); tick(20);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL green_l1_dwell: got %h want %h", got, want); end
      exp_q.push_back(exp_v(ST_ATTACK, 2, 0, 0)); tick(1);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL green_l2: got %h want %h", got, want); end
      exp_q.push_back(exp_v(ST_CONNECT, 3, 0, 0)); tick(10);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL green_connect: got %h want %h", got, want); end
      red = 1; yellow = 1;
      exp_q.push_back(exp_v(ST_CONNECT, 3, 4, 0)); tick(4);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL connect_ignores: got %h want %h", got, want); end
      restart = 1; red = 0; yellow = 0; green = 0;
      exp_q.push_back(exp_v(ST_LAY_LOW, 0, 0, 0)); tick(1); restart = 0;
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL connect_restart: got %h want %h", got, want); end
   endtask

   task automatic test_yellow();
      do_reset();
      green = 1; tick(57); green = 0;
      exp_q.push_back(exp_v(ST_ATTACK, 2, 3, 0)); tick(3);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL yellow_pre: got %h want %h", got, want); end
      yellow = 1;
      exp_q.push_back(exp_v(ST_ATTACK, 1, 0, 0)); tick(1); yellow = 0;
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL yellow_l2_to_l1: got %h want %h", got, want); end
      yellow = 1;
      exp_q.push_back(exp_v(ST_LAY_LOW, 0, 0, 0)); tick(1);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL yellow_l1_to_l0: got %h want %h", got, want); end
      exp_q.push_back(exp_v(ST_LAY_LOW, 0, 5, 0)); tick(5);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL yellow_l0_stays: got %h want %h", got, want); end
      yellow = 0; restart = 1;
      exp_q.push_back(exp_v(ST_LAY_LOW, 0, 6, 0)); tick(1); restart = 0;
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL restart_ignored: got %h want %h", got, want); end
   endtask

   task automatic test_cheat_escape();
      do_reset();
      green = 1; tick(36); green = 0;
      red = 1;
      exp_q.push_back(exp_v(ST_CHEAT, 1, 0, 1));
      exp_q.push_back(exp_v(ST_CHEAT, 1, 0, 1));
      tick(1); red = 0;
      for (int d = 0; d < 2; d++) begin
         got = obs(d); want = exp_q.pop_front(); n_chk++;
         if (got !== want) begin n_fail++; $display("FAIL cheat_entry dut%0d: got %h want %h", d, got, want); end
      end
      exp_q.push_back(exp_v(ST_CHEAT, 1, 25, 1)); tick(25);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL cheat_window: got %h want %h", got, want); end
      exp_q.push_back(exp_v(ST_LAY_LOW, 0, 0, 1));
      exp_q.push_back(exp_v(ST_ATTACK, 1, 0, 1));
      tick(1);
      for (int d = 0; d < 2; d++) begin
         got = obs(d); want = exp_q.pop_front(); n_chk++;
         if (got !== want) begin n_fail++; $display("FAIL cheat_exit dut%0d: got %h want %h", d, got, want); end
      end
   endtask

   task automatic test_cheat_fail();
      do_reset();
      red = 1;
      exp_q.push_back(exp_v(ST_CHEAT, 0, 0, 1)); tick(1);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL fail_cheat_entry: got %h want %h", got, want); end
      exp_q.push_back(exp_v(ST_CHEAT, 0, 25, 1)); tick(25);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL fail_window_end: got %h want %h", got, want); end
      exp_q.push_back(exp_v(ST_FAIL, 0, 0, 1)); tick(1);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL fail_entry: got %h want %h", got, want); end
      green = 1;
      exp_q.push_back(exp_v(ST_FAIL, 0, 3, 1)); tick(3);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL fail_ignores: got %h want %h", got, want); end
      green = 0; red = 0; restart = 1;
      exp_q.push_back(exp_v(ST_LAY_LOW, 0, 0, 0)); tick(1); restart = 0;
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL fail_restart: got %h want %h", got, want); end
   endtask

   task automatic test_max_cheats();
      do_reset();
      for (int i = 1; i <= 2; i++) begin
         red = 1;
         exp_q.push_back(exp_v(ST_CHEAT, 0, 0, i)); tick(1); red = 0;
         got = obs(2); want = exp_q.pop_front(); n_chk++;
         if (got !== want) begin n_fail++; $display("FAIL max_cheat_%0d: got %h want %h", i, got, want); end
         exp_q.push_back(exp_v(ST_LAY_LOW, 0, 0, i)); tick(26);
         got = obs(2); want = exp_q.pop_front(); n_chk++;
         if (got !== want) begin n_fail++; $display("FAIL max_escape_%0d: got %h want %h", i, got, want); end
      end
      red = 1;
      exp_q.push_back(exp_v(ST_FAIL, 0, 0, 3)); tick(1); red = 0;
      got = obs(2); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL max_third_red: got %h want %h", got, want); end
   endtask

   task automatic test_async_reset();
      do_reset();
      green = 1;
      exp_q.push_back(exp_v(ST_ATTACK, 1, 4, 0)); tick(40);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL async_pre: got %h want %h", got, want); end
      #2 reset_n = 1'b0;
      exp_q.push_back(exp_v(ST_LAY_LOW, 0, 0, 0)); #1;
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL async_reset: got %h want %h", got, want); end
      #1 reset_n = 1'b1;
      yellow = 1; red = 1;
      exp_q.push_back(exp_v(ST_CHEAT, 0, 0, 1)); tick(1);
      got = obs(0); want = exp_q.pop_front(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL all_alerts_red: got %h want %h", got, want); end
      green = 0; yellow = 0; red = 0;
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      reset_n = 1'b0;
      green = 0; yellow = 0; red = 0; restart = 0;
      test_reset();
      test_green_ladder();
      test_yellow();
      test_cheat_escape();
      test_cheat_fail();
      test_max_cheats();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
